// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its two requesters (CPU, debug) and the external memory port.
// The arbiter takes the master view; the surrounding system or a bench takes the slave view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic                  cpu_fetch_req_in;
  logic                  cpu_read_req_in;
  logic                  cpu_write_req_in;
  logic [ADDR_W-1:0]     cpu_addr_in;
  logic [DATA_W-1:0]     cpu_wdata_in;
  logic [2*DATA_W-1:0]   inst_out;
  logic [DATA_W-1:0]     rdata_out;
  logic                  mem_busy_out;
  logic                  inst_fetch_done_out;
  logic                  data_read_done_out;

  logic                  dbg_req_in;
  logic                  dbg_we_in;
  logic [ADDR_W-1:0]     dbg_addr_in;
  logic [DATA_W-1:0]     dbg_wdata_in;
  logic                  dbg_gnt_out;
  logic                  dbg_done_out;
  logic [DATA_W-1:0]     dbg_rdata_out;

  logic                  mem_req_out;
  logic                  mem_we_out;
  logic [ADDR_W-1:0]     mem_addr_out;
  logic [DATA_W-1:0]     mem_wdata_out;
  logic                  mem_ack_in;
  logic [DATA_W-1:0]     mem_rdata_in;

  modport master (
    input  cpu_fetch_req_in, cpu_read_req_in, cpu_write_req_in, cpu_addr_in, cpu_wdata_in,
    output inst_out, rdata_out, mem_busy_out, inst_fetch_done_out, data_read_done_out,
    input  dbg_req_in, dbg_we_in, dbg_addr_in, dbg_wdata_in,
    output dbg_gnt_out, dbg_done_out, dbg_rdata_out,
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  mem_ack_in, mem_rdata_in
  );

  modport slave (
    output cpu_fetch_req_in, cpu_read_req_in, cpu_write_req_in, cpu_addr_in, cpu_wdata_in,
    input  inst_out, rdata_out, mem_busy_out, inst_fetch_done_out, data_read_done_out,
    output dbg_req_in, dbg_we_in, dbg_addr_in, dbg_wdata_in,
    input  dbg_gnt_out, dbg_done_out, dbg_rdata_out,
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output mem_ack_in, mem_rdata_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-way round-robin arbiter sharing one byte-wide memory port between the CPU
// (pulse requests, 2-beat big-endian instruction fetch) and the debug/loader port.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input logic          clk_in,
  input logic          reset_n_in,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_FINISH} state_t;
  typedef enum logic [2:0] {K_FETCH, K_READ, K_WRITE, K_DBG_RD, K_DBG_WR} kind_t;

  state_t              state_q;
  kind_t               kind_q;
  logic                last_dbg_q;
  logic                lat_v_q;
  kind_t               lat_kind_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [DATA_W-1:0]   lat_wdata_q;
  logic [DATA_W-1:0]   inst_hi_q;
  logic [2*DATA_W-1:0] inst_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   dbg_rdata_q;
  logic                busy_q;
  logic                ifd_q;
  logic                drd_q;
  logic                dbg_gnt_q;
  logic                dbg_done_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic  cur_dbg_c, cpu_pulse_c, cpu_in_flight_c, cpu_take_c;
  logic  dbg_req_v_c, grant_cpu_c, grant_dbg_c, lat_v_next_c, cpu_active_next_c;
  kind_t new_kind_c;

  // Request acceptance and arbitration. The debug requester still holds its
  // request during its done cycle, so that cycle's level is not a new request.
  always_comb begin
    cur_dbg_c         = (kind_q == K_DBG_RD) || (kind_q == K_DBG_WR);
    cpu_pulse_c       = bus.cpu_fetch_req_in || bus.cpu_read_req_in || bus.cpu_write_req_in;
    cpu_in_flight_c   = ((state_q == S_BEAT0) || (state_q == S_BEAT1)) && !cur_dbg_c;
    cpu_take_c        = cpu_pulse_c && !lat_v_q && !cpu_in_flight_c;
    new_kind_c        = bus.cpu_fetch_req_in ? K_FETCH :
                        (bus.cpu_read_req_in ? K_READ : K_WRITE);
    dbg_req_v_c       = bus.dbg_req_in && !dbg_done_q;
    grant_cpu_c       = (state_q == S_IDLE) && lat_v_q && (!dbg_req_v_c || last_dbg_q);
    grant_dbg_c       = (state_q == S_IDLE) && dbg_req_v_c && !grant_cpu_c;
    lat_v_next_c      = cpu_take_c || (lat_v_q && !grant_cpu_c);
    cpu_active_next_c = grant_cpu_c ||
                        (cpu_in_flight_c &&
                         !(bus.mem_ack_in && ((state_q == S_BEAT1) || (kind_q != K_FETCH))));
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= S_IDLE;
      kind_q      <= K_FETCH;
      last_dbg_q  <= 1'b1;
      lat_v_q     <= 1'b0;
      lat_kind_q  <= K_FETCH;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      inst_hi_q   <= '0;
      inst_q      <= '0;
      rdata_q     <= '0;
      dbg_rdata_q <= '0;
      busy_q      <= 1'b0;
      ifd_q       <= 1'b0;
      drd_q       <= 1'b0;
      dbg_gnt_q   <= 1'b0;
      dbg_done_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      ifd_q      <= 1'b0;
      drd_q      <= 1'b0;
      dbg_done_q <= 1'b0;
      lat_v_q    <= lat_v_next_c;
      busy_q     <= lat_v_next_c || cpu_active_next_c;
      if (cpu_take_c) begin
        lat_kind_q  <= new_kind_c;
        lat_addr_q  <= bus.cpu_addr_in;
        lat_wdata_q <= bus.cpu_wdata_in;
      end
      case (state_q)
        S_IDLE: begin
          if (grant_cpu_c) begin
            kind_q      <= lat_kind_q;
            mem_req_q   <= 1'b1;
            mem_we_q    <= (lat_kind_q == K_WRITE);
            mem_addr_q  <= lat_addr_q;
            mem_wdata_q <= lat_wdata_q;
            state_q     <= S_BEAT0;
          end else if (grant_dbg_c) begin
            kind_q      <= bus.dbg_we_in ? K_DBG_WR : K_DBG_RD;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dbg_we_in;
            mem_addr_q  <= bus.dbg_addr_in;
            mem_wdata_q <= bus.dbg_wdata_in;
            dbg_gnt_q   <= 1'b1;
            state_q     <= S_BEAT0;
          end
        end
        S_BEAT0: begin
          if (bus.mem_ack_in) begin
            if (kind_q == K_FETCH) begin
              // Second beat follows directly at the next (wrapping) byte address.
              inst_hi_q  <= bus.mem_rdata_in;
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
              state_q    <= S_BEAT1;
            end else begin
              if (kind_q == K_READ)   rdata_q     <= bus.mem_rdata_in;
              if (kind_q == K_DBG_RD) dbg_rdata_q <= bus.mem_rdata_in;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              state_q   <= S_FINISH;
            end
          end
        end
        S_BEAT1: begin
          if (bus.mem_ack_in) begin
            inst_q    <= {inst_hi_q, bus.mem_rdata_in};
            mem_req_q <= 1'b0;
            state_q   <= S_FINISH;
          end
        end
        S_FINISH: begin
          ifd_q      <= (kind_q == K_FETCH);
          drd_q      <= (kind_q == K_READ);
          dbg_done_q <= cur_dbg_c;
          dbg_gnt_q  <= 1'b0;
          last_dbg_q <= cur_dbg_c;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.inst_out            = inst_q;
  assign bus.rdata_out           = rdata_q;
  assign bus.mem_busy_out        = busy_q;
  assign bus.inst_fetch_done_out = ifd_q;
  assign bus.data_read_done_out  = drd_q;
  assign bus.dbg_gnt_out         = dbg_gnt_q;
  assign bus.dbg_done_out        = dbg_done_q;
  assign bus.dbg_rdata_out       = dbg_rdata_q;
  assign bus.mem_req_out         = mem_req_q;
  assign bus.mem_we_out          = mem_we_q;
  assign bus.mem_addr_out        = mem_addr_q;
  assign bus.mem_wdata_out       = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, waited read, write, round-robin,
// address wrap with pulse priority, and reset in the middle of a fetch.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n_ifd = 0;
  int   n_drd = 0;
  int   n_dd  = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Done-pulse counters used to prove that no extra pulses appear.
  always @(posedge clk) begin
    if (bus.inst_fetch_done_out) n_ifd <= n_ifd + 1;
    if (bus.data_read_done_out)  n_drd <= n_drd + 1;
    if (bus.dbg_done_out)        n_dd  <= n_dd + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    bus.cpu_fetch_req_in = 1'b0;
    bus.cpu_read_req_in  = 1'b0;
    bus.cpu_write_req_in = 1'b0;
    bus.cpu_addr_in      = 16'h0000;
    bus.cpu_wdata_in     = 8'h00;
    bus.dbg_req_in       = 1'b0;
    bus.dbg_we_in        = 1'b0;
    bus.dbg_addr_in      = 16'h0000;
    bus.dbg_wdata_in     = 8'h00;
    bus.mem_ack_in       = 1'b0;
    bus.mem_rdata_in     = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick(2);
    checks++; if (bus.mem_req_out !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req_out); end
    checks++; if (bus.mem_busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.mem_busy_out); end
    checks++; if (bus.inst_out !== 16'h0000) begin errors++; $display("FAIL reset_inst got %h exp 0000", bus.inst_out); end
    checks++; if ({bus.rdata_out, bus.dbg_rdata_out} !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", {bus.rdata_out, bus.dbg_rdata_out}); end
    checks++; if ({bus.dbg_gnt_out, bus.dbg_done_out, bus.inst_fetch_done_out, bus.data_read_done_out} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {bus.dbg_gnt_out, bus.dbg_done_out, bus.inst_fetch_done_out, bus.data_read_done_out});
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  // Zero-wait fetch at 0x0010: beats at 0x0010/0x0011, done pulse 5 cycles after the request.
  task automatic test_fetch();
    int f0;
    f0 = n_ifd;
    bus.cpu_fetch_req_in = 1'b1; bus.cpu_addr_in = 16'h0010;
    checks++; if (bus.mem_busy_out !== 1'b0) begin errors++; $display("FAIL fetch_busy_c0 got %b exp 0", bus.mem_busy_out); end
    tick(1);
    bus.cpu_fetch_req_in = 1'b0;
    checks++; if (bus.mem_busy_out !== 1'b1) begin errors++; $display("FAIL fetch_busy_c1 got %b exp 1", bus.mem_busy_out); end
    tick(1);
    checks++; if ({bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out} !== {2'b10, 16'h0010}) begin
      errors++; $display("FAIL fetch_beat0 got req=%b we=%b addr=%h exp 1 0 0010", bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out);
    end
    bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 8'hA5;
    tick(1);
    checks++; if ({bus.mem_req_out, bus.mem_addr_out} !== {1'b1, 16'h0011}) begin
      errors++; $display("FAIL fetch_beat1 got req=%b addr=%h exp 1 0011", bus.mem_req_out, bus.mem_addr_out);
    end
    checks++; if (bus.mem_busy_out !== 1'b1) begin errors++; $display("FAIL fetch_busy_c3 got %b exp 1", bus.mem_busy_out); end
    bus.mem_rdata_in = 8'h3C;
    tick(1);
    bus.mem_ack_in = 1'b0;
    checks++; if ({bus.mem_req_out, bus.mem_busy_out, bus.inst_fetch_done_out} !== 3'b000) begin
      errors++; $display("FAIL fetch_finish got req=%b busy=%b done=%b exp 000", bus.mem_req_out, bus.mem_busy_out, bus.inst_fetch_done_out);
    end
    tick(1);
    checks++; if (bus.inst_fetch_done_out !== 1'b1) begin errors++; $display("FAIL fetch_done_c5 got %b exp 1", bus.inst_fetch_done_out); end
    checks++; if (bus.inst_out !== 16'hA53C) begin errors++; $display("FAIL fetch_inst got %h exp a53c", bus.inst_out); end
    tick(2);
    checks++; if (n_ifd - f0 !== 1) begin errors++; $display("FAIL fetch_done_count got %0d exp 1", n_ifd - f0); end
  endtask

  // Read at 0x1234 with 3 wait cycles before the ack.
  task automatic test_read_wait();
    int req_cycles;
    int r0;
    int d0;
    r0 = n_drd; d0 = n_dd; req_cycles = 0;
    bus.cpu_read_req_in = 1'b1; bus.cpu_addr_in = 16'h1234;
    tick(1);
    bus.cpu_read_req_in = 1'b0;
    tick(1);
    for (int c = 0; c < 4; c++) begin
      if (bus.mem_req_out === 1'b1 && bus.mem_addr_out === 16'h1234) req_cycles++;
      if (c == 3) begin bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 8'h7E; end
      tick(1);
    end
    bus.mem_ack_in = 1'b0;
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL read_req_cycles got %0d exp 4", req_cycles); end
    checks++; if (bus.mem_req_out !== 1'b0) begin errors++; $display("FAIL read_req_drop got %b exp 0", bus.mem_req_out); end
    tick(1);
    checks++; if ({bus.data_read_done_out, bus.rdata_out} !== {1'b1, 8'h7E}) begin
      errors++; $display("FAIL read_done got done=%b rdata=%h exp 1 7e", bus.data_read_done_out, bus.rdata_out);
    end
    tick(2);
    checks++; if (n_drd - r0 !== 1) begin errors++; $display("FAIL read_done_count got %0d exp 1", n_drd - r0); end
    checks++; if (n_dd !== d0 || bus.dbg_gnt_out !== 1'b0) begin errors++; $display("FAIL read_dbg_quiet got done=%0d gnt=%b exp 0 0", n_dd - d0, bus.dbg_gnt_out); end
  endtask

  // Write 0x55 to 0x2000: one write beat, no done pulse, busy falls after the ack.
  task automatic test_write();
    int r0;
    int f0;
    r0 = n_drd; f0 = n_ifd;
    bus.cpu_write_req_in = 1'b1; bus.cpu_addr_in = 16'h2000; bus.cpu_wdata_in = 8'h55;
    tick(1);
    bus.cpu_write_req_in = 1'b0;
    tick(1);
    checks++; if ({bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out, bus.mem_wdata_out} !== {2'b11, 16'h2000, 8'h55}) begin
      errors++; $display("FAIL write_beat got req=%b we=%b addr=%h wdata=%h exp 1 1 2000 55", bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out, bus.mem_wdata_out);
    end
    checks++; if (bus.mem_busy_out !== 1'b1) begin errors++; $display("FAIL write_busy_beat got %b exp 1", bus.mem_busy_out); end
    bus.mem_ack_in = 1'b1;
    tick(1);
    bus.mem_ack_in = 1'b0;
    checks++; if ({bus.mem_busy_out, bus.mem_req_out} !== 2'b00) begin errors++; $display("FAIL write_after_ack got busy=%b req=%b exp 0 0", bus.mem_busy_out, bus.mem_req_out); end
    tick(3);
    checks++; if (n_drd !== r0 || n_ifd !== f0 || bus.mem_req_out !== 1'b0) begin
      errors++; $display("FAIL write_no_done got drd=%0d ifd=%0d req=%b exp 0 0 0", n_drd - r0, n_ifd - f0, bus.mem_req_out);
    end
  endtask

  // CPU and debug contend: CPU first after reset, then DBG, then CPU again.
  task automatic test_round_robin();
    do_reset();
    bus.cpu_read_req_in = 1'b1; bus.cpu_addr_in = 16'h0100;
    tick(1);
    bus.cpu_read_req_in = 1'b0;
    bus.dbg_req_in = 1'b1; bus.dbg_we_in = 1'b0; bus.dbg_addr_in = 16'h0200;
    tick(1);
    checks++; if ({bus.mem_req_out, bus.mem_addr_out, bus.dbg_gnt_out} !== {1'b1, 16'h0100, 1'b0}) begin
      errors++; $display("FAIL rr_first_cpu got req=%b addr=%h gnt=%b exp 1 0100 0", bus.mem_req_out, bus.mem_addr_out, bus.dbg_gnt_out);
    end
    bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 8'h11;
    tick(1);
    bus.mem_ack_in = 1'b0;
    bus.cpu_read_req_in = 1'b1; bus.cpu_addr_in = 16'h0101;
    tick(1);
    bus.cpu_read_req_in = 1'b0;
    checks++; if ({bus.data_read_done_out, bus.rdata_out} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL rr_cpu_done got done=%b rdata=%h exp 1 11", bus.data_read_done_out, bus.rdata_out);
    end
    tick(1);
    checks++; if ({bus.mem_req_out, bus.mem_addr_out, bus.dbg_gnt_out, bus.mem_busy_out} !== {1'b1, 16'h0200, 2'b11}) begin
      errors++; $display("FAIL rr_second_dbg got req=%b addr=%h gnt=%b busy=%b exp 1 0200 1 1", bus.mem_req_out, bus.mem_addr_out, bus.dbg_gnt_out, bus.mem_busy_out);
    end
    bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 8'h22;
    tick(1);
    bus.mem_ack_in = 1'b0;
    tick(1);
    checks++; if ({bus.dbg_done_out, bus.dbg_rdata_out, bus.dbg_gnt_out} !== {1'b1, 8'h22, 1'b0}) begin
      errors++; $display("FAIL rr_dbg_done got done=%b rdata=%h gnt=%b exp 1 22 0", bus.dbg_done_out, bus.dbg_rdata_out, bus.dbg_gnt_out);
    end
    tick(1);
    checks++; if ({bus.mem_req_out, bus.mem_addr_out, bus.dbg_gnt_out} !== {1'b1, 16'h0101, 1'b0}) begin
      errors++; $display("FAIL rr_third_cpu got req=%b addr=%h gnt=%b exp 1 0101 0", bus.mem_req_out, bus.mem_addr_out, bus.dbg_gnt_out);
    end
    bus.dbg_req_in = 1'b0;
    bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 8'h33;
    tick(1);
    bus.mem_ack_in = 1'b0;
    tick(1);
    checks++; if ({bus.data_read_done_out, bus.rdata_out} !== {1'b1, 8'h33}) begin
      errors++; $display("FAIL rr_cpu2_done got done=%b rdata=%h exp 1 33", bus.data_read_done_out, bus.rdata_out);
    end
    tick(2);
  endtask

  // Fetch at 0xFFFF wraps to 0x0000; the simultaneous write pulse is dropped.
  task automatic test_wrap_priority();
    bus.cpu_fetch_req_in = 1'b1; bus.cpu_write_req_in = 1'b1;
    bus.cpu_addr_in = 16'hFFFF; bus.cpu_wdata_in = 8'h99;
    tick(1);
    bus.cpu_fetch_req_in = 1'b0; bus.cpu_write_req_in = 1'b0;
    tick(1);
    checks++; if ({bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out} !== {2'b10, 16'hFFFF}) begin
      errors++; $display("FAIL wrap_beat0 got req=%b we=%b addr=%h exp 1 0 ffff", bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out);
    end
    bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 8'h12;
    tick(1);
    checks++; if ({bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out} !== {2'b10, 16'h0000}) begin
      errors++; $display("FAIL wrap_beat1 got req=%b we=%b addr=%h exp 1 0 0000", bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out);
    end
    bus.mem_rdata_in = 8'h34;
    tick(1);
    bus.mem_ack_in = 1'b0;
    tick(1);
    checks++; if ({bus.inst_fetch_done_out, bus.inst_out} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL wrap_inst got done=%b inst=%h exp 1 1234", bus.inst_fetch_done_out, bus.inst_out);
    end
    tick(3);
    checks++; if ({bus.mem_req_out, bus.mem_busy_out} !== 2'b00) begin
      errors++; $display("FAIL prio_write_dropped got req=%b busy=%b exp 0 0", bus.mem_req_out, bus.mem_busy_out);
    end
  endtask

  // Reset asserted during BEAT1; a late ack is ignored and the next read works.
  task automatic test_reset_mid_fetch();
    int f0;
    bus.cpu_fetch_req_in = 1'b1; bus.cpu_addr_in = 16'h0040;
    tick(1);
    bus.cpu_fetch_req_in = 1'b0;
    tick(1);
    bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 8'hAB;
    tick(1);
    bus.mem_ack_in = 1'b0;
    checks++; if ({bus.mem_req_out, bus.mem_addr_out} !== {1'b1, 16'h0041}) begin
      errors++; $display("FAIL rst_mid_beat1 got req=%b addr=%h exp 1 0041", bus.mem_req_out, bus.mem_addr_out);
    end
    f0 = n_ifd;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.mem_req_out, bus.mem_busy_out, bus.inst_out} !== {2'b00, 16'h0000}) begin
      errors++; $display("FAIL rst_mid_immediate got req=%b busy=%b inst=%h exp 0 0 0000", bus.mem_req_out, bus.mem_busy_out, bus.inst_out);
    end
    tick(1);
    rst_n = 1'b1;
    bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 8'hFF;
    tick(1);
    bus.mem_ack_in = 1'b0;
    tick(3);
    checks++; if (n_ifd !== f0 || bus.inst_out !== 16'h0000 || bus.mem_req_out !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_done got ifd=%0d inst=%h req=%b exp 0 0000 0", n_ifd - f0, bus.inst_out, bus.mem_req_out);
    end
    bus.cpu_read_req_in = 1'b1; bus.cpu_addr_in = 16'h0050;
    tick(1);
    bus.cpu_read_req_in = 1'b0;
    tick(1);
    checks++; if ({bus.mem_req_out, bus.mem_addr_out} !== {1'b1, 16'h0050}) begin
      errors++; $display("FAIL rst_after_read_beat got req=%b addr=%h exp 1 0050", bus.mem_req_out, bus.mem_addr_out);
    end
    bus.mem_ack_in = 1'b1; bus.mem_rdata_in = 8'h5A;
    tick(1);
    bus.mem_ack_in = 1'b0;
    tick(1);
    checks++; if ({bus.data_read_done_out, bus.rdata_out} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL rst_after_read_done got done=%b rdata=%h exp 1 5a", bus.data_read_done_out, bus.rdata_out);
    end
    tick(2);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch();
    test_read_wait();
    test_write();
    test_round_robin();
    test_wrap_priority();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
